// File: rtl/alu_req_sequencer.sv
//------------------------------------------------------------------------------
// Module      : alu_req_sequencer
// Description : Round-robin sequencer sharing one 8-bit ALU between two
//               valid/ready requesters; returns tagged results on one port.
//               Optional op_count output enabled by `define ALU_SEQ_STATS_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_req_sequencer #(
    parameter int OP_W        = 3,
    parameter int ALU_LATENCY = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [7:0]      req0_a,
    input  logic [7:0]      req0_b,
    input  logic [OP_W-1:0] req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [7:0]      req1_a,
    input  logic [7:0]      req1_b,
    input  logic [OP_W-1:0] req1_op,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [OP_W-1:0] alu_op,
    input  logic [7:0]      alu_y,
    input  logic            alu_carry,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [7:0]      rsp_y,
    output logic            rsp_carry,
    output logic            busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [7:0]      op_count
`endif
);

    localparam int c_cnt_w = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_lat_load = c_cnt_w'(ALU_LATENCY);

    typedef logic [1:0] state_t;
    localparam state_t c_idle = 2'd0;
    localparam state_t c_wait = 2'd1;
    localparam state_t c_resp = 2'd2;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_rr_last;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [7:0]          r_alu_a;
    logic [7:0]          r_alu_b;
    logic [OP_W-1:0]     r_alu_op;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [7:0]          r_rsp_y;
    logic                r_rsp_carry;

    logic                w_any_valid;
    logic                w_grant_id;
    logic                w_accept;
    logic                w_capture;
    logic                w_rsp_done;

    assign w_any_valid = req0_valid | req1_valid;
    // Under contention the requester that was not served last wins.
    assign w_grant_id  = (req0_valid & req1_valid) ? ~r_rr_last : req1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            c_idle: begin
                if (w_any_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_wait;
                end
            end
            c_wait: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = c_resp;
                end
            end
            c_resp: begin
                if (r_rsp_valid && rsp_ready) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = c_idle;
                end
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last   <= 1'b1;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_y     <= '0;
            r_rsp_carry <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_a  <= w_grant_id ? req1_a  : req0_a;
                r_alu_b  <= w_grant_id ? req1_b  : req0_b;
                r_alu_op <= w_grant_id ? req1_op : req0_op;
                r_rsp_id <= w_grant_id;
                r_cnt    <= c_lat_load;
            end
            if ((r_state == c_wait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_y     <= alu_y;
                r_rsp_carry <= alu_carry;
                r_rsp_valid <= 1'b1;
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
                r_rr_last   <= r_rsp_id;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [7:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (w_rsp_done) begin
            r_op_count <= r_op_count + 8'd1;
        end
    end

    assign op_count = r_op_count;
`endif

    assign req0_ready = w_accept & ~w_grant_id;
    assign req1_ready = w_accept &  w_grant_id;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_op     = r_alu_op;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_y      = r_rsp_y;
    assign rsp_carry  = r_rsp_carry;
    assign busy       = (r_state != c_idle);

endmodule

`default_nettype wire

// File: tb/tb_alu_req_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_alu_req_sequencer
// Description : Directed self-checking bench; three sequencers (latency 0/2/3)
//               share stimulus, each driving its own ALU model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_req_sequencer;

    logic       clk;
    logic       rst;
    logic       req0_valid;
    logic [7:0] req0_a;
    logic [7:0] req0_b;
    logic [2:0] req0_op;
    logic       req1_valid;
    logic [7:0] req1_a;
    logic [7:0] req1_b;
    logic [2:0] req1_op;
    logic       rsp_ready;

    logic [2:0] req0_ready;
    logic [2:0] req1_ready;
    logic [2:0] rsp_valid;
    logic [2:0] rsp_id;
    logic [2:0] rsp_carry;
    logic [2:0] busy;
    logic [2:0] alu_c;
    logic [7:0] alu_a  [3];
    logic [7:0] alu_b  [3];
    logic [2:0] alu_op [3];
    logic [7:0] alu_y  [3];
    logic [7:0] rsp_y  [3];
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] op_count [3];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            default: return {1'b0, a & b};
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_req_sequencer #(
            .OP_W       (3),
            .ALU_LATENCY((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .req0_valid(req0_valid),
            .req0_ready(req0_ready[g]),
            .req0_a    (req0_a),
            .req0_b    (req0_b),
            .req0_op   (req0_op),
            .req1_valid(req1_valid),
            .req1_ready(req1_ready[g]),
            .req1_a    (req1_a),
            .req1_b    (req1_b),
            .req1_op   (req1_op),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_op    (alu_op[g]),
            .alu_y     (alu_y[g]),
            .alu_carry (alu_c[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready),
            .rsp_id    (rsp_id[g]),
            .rsp_y     (rsp_y[g]),
            .rsp_carry (rsp_carry[g]),
            .busy      (busy[g])
`ifdef ALU_SEQ_STATS_EN
            ,
            .op_count  (op_count[g])
`endif
        );
        assign {alu_c[g], alu_y[g]} = alu_model(alu_a[g], alu_b[g], alu_op[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Issues one op on DUT d from requester who, with rsp_ready held high.
    task automatic run_op(input int d, input bit who, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, output logic id, output logic [7:0] y,
                          output logic c, output bit ok);
        id = 1'b0; y = '0; c = 1'b0; ok = 1'b0;
        rsp_ready = 1'b1;
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        for (int i = 0; i < 20; i++) begin
            if (who ? req1_ready[d] : req0_ready[d]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (ok) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (rsp_valid[d]) begin
                    ok = 1'b1;
                    id = rsp_id[d];
                    y  = rsp_y[d];
                    c  = rsp_carry[d];
                    break;
                end
                tick();
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       got_id;
        logic [7:0] got_y;
        logic       got_c;
        bit         ok;
        int         n;
        int         last;
        bit         seen;

        // Reset state and single add on the combinational-latency DUT
        do_reset();
        check_eq("reset_outputs",
                 {alu_a[0], alu_b[0], alu_op[0], rsp_y[0], rsp_id[0], rsp_carry[0],
                  rsp_valid[0], busy[0], req0_ready[0], req1_ready[0]}, 32'h0);
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 3'd0;
        rsp_ready  = 1'b1;
        #1;
        check_eq("add_ready_T", {req0_ready[0], req1_ready[0], busy[0]}, 3'b100);
        tick();
        req0_valid = 1'b0;
        check_eq("add_T1", {busy[0], rsp_valid[0]}, 2'b10);
        check_eq("add_alu_ops", {alu_a[0], alu_b[0], alu_op[0]}, {8'h12, 8'h34, 3'd0});
        tick();
        check_eq("add_T2_flags", {busy[0], rsp_valid[0], rsp_id[0], rsp_carry[0]}, 4'b1100);
        check_eq("add_T2_y", rsp_y[0], 8'h46);
        tick();
        check_eq("add_T3_idle", {busy[0], rsp_valid[0]}, 2'b00);

        // Carry out of an add from requester 1
        do_reset();
        run_op(0, 1'b1, 8'hFF, 8'h01, 3'd0, got_id, got_y, got_c, ok);
        check_eq("carry_done", ok, 1);
        check_eq("carry_rsp", {got_id, got_y, got_c}, {1'b1, 8'h00, 1'b1});

        // Contention: both held valid from reset alternate 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd1; req0_op = 3'd0;
        req1_valid = 1'b1; req1_a = 8'd2; req1_b = 8'd2; req1_op = 3'd0;
        rsp_ready  = 1'b1;
        #1;
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && n < 4; cyc++) begin
            if (rsp_valid[0]) begin
                check_eq($sformatf("contend_id%0d", n), rsp_id[0], n % 2);
                check_eq($sformatf("contend_y%0d", n), rsp_y[0], (n % 2) ? 4 : 2);
                if (n > 0) check_eq("contend_period", cyc - last, 3);
                last = cyc;
                n++;
            end
            tick();
        end
        check_eq("contend_count", n, 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Latency 2 with back-pressure
        do_reset();
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_op = 3'd0;
        rsp_ready  = 1'b0;
        #1;
        check_eq("bp_ready_T", req0_ready[1], 1'b1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("bp_wait_T%0d", k), {busy[1], rsp_valid[1]}, 2'b10);
        end
        tick();
        check_eq("bp_valid_T4", rsp_valid[1], 1'b1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            check_eq("bp_stall_hold", {rsp_valid[1], req0_ready[1], rsp_y[1]}, {1'b1, 1'b0, 8'h30});
        end
        tick();
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_hs_cycle", {rsp_valid[1], req0_ready[1]}, 2'b10);
        tick();
        check_eq("bp_next_accept", {rsp_valid[1], req0_ready[1]}, 2'b01);
        tick();
        req0_valid = 1'b0;

        // Latency 3 with reset during WAIT
        do_reset();
        req0_valid = 1'b1; req0_a = 8'd5; req0_b = 8'd6; req0_op = 3'd0;
        rsp_ready  = 1'b1;
        #1;
        check_eq("rst_ready_T", req0_ready[2], 1'b1);
        tick();
        req0_valid = 1'b0;
        check_eq("rst_busy_T1", busy[2], 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_outputs",
                 {alu_a[2], alu_b[2], alu_op[2], rsp_y[2], rsp_id[2], rsp_carry[2],
                  rsp_valid[2], busy[2]}, 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            seen = seen | rsp_valid[2];
            tick();
        end
        check_eq("rst_no_rsp", seen, 1'b0);
        run_op(2, 1'b0, 8'd7, 8'd8, 3'd0, got_id, got_y, got_c, ok);
        check_eq("rst_after_done", ok, 1);
        check_eq("rst_after_rsp", {got_id, got_y, got_c}, {1'b0, 8'd15, 1'b0});

        // Subtract opcode passes through unchanged
        run_op(2, 1'b1, 8'h05, 8'h07, 3'd1, got_id, got_y, got_c, ok);
        check_eq("sub_rsp", {ok, got_id, got_y, got_c}, {1'b1, 1'b1, 8'hFE, 1'b1});

`ifdef ALU_SEQ_STATS_EN
        do_reset();
        check_eq("stats_reset", op_count[0], 8'd0);
        n = 0;
        for (int k = 0; k < 257; k++) begin
            run_op(0, 1'b0, 8'd1, 8'd2, 3'd0, got_id, got_y, got_c, ok);
            if (ok) n++;
        end
        check_eq("stats_ops_ok", n, 257);
        check_eq("stats_wrap", op_count[0], 8'd1);
        req0_valid = 1'b1; req0_a = 8'd3; req0_b = 8'd4; req0_op = 3'd0;
        rsp_ready  = 1'b0;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        check_eq("stats_stall_valid", rsp_valid[0], 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("stats_stall_hold", op_count[0], 8'd1);
        end
        rsp_ready = 1'b1;
        tick();
        check_eq("stats_after_hs", op_count[0], 8'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
